ads_int_to_float: RTL and testbench

Converts each signed 24-bit ADS1292 channel sample into an IEEE-754 single-precision float. It sits between the ADS1292 SPI sample unpacker and the float IIR filter chain, and feeds `iir_notch` directly through `o_X_DATA` / `o_X_DATA_VALID` / `i_X_DATA_READY`. Conversion is exact: any 24-bit magnitude fits the 24-bit significand, so no rounding is needed. An iterative normaliser shifts one bit per cycle, trading a variable latency for a small footprint.

---
 rtl/ads_int_to_float_pkg.sv | 15 +
 rtl/ads_int_to_float.sv | 117 +++++++++++
 tb/tb_ads_int_to_float.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ads_int_to_float_pkg.sv
// Shared filter-chain package: converter state encodings and IEEE-754 single constants.
package ads_int_to_float_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ABS  = 2'd1,
      ST_NORM = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   localparam int unsigned FLOAT_EXP_BIAS = 127;
   localparam logic [31:0] FLOAT_ZERO     = 32'h0000_0000;
   localparam logic [31:0] FLOAT_ONE      = 32'h3f80_0000;

endpackage

// File: rtl/ads_int_to_float.sv
// Exact signed-integer to IEEE-754 single converter with a one-bit-per-cycle normaliser.
module ads_int_to_float #(
   parameter int unsigned IN_WIDTH = 24
) (
   input  logic                i_CLK,
   input  logic                i_RST,
   input  logic [IN_WIDTH-1:0] i_ADC_DATA,
   input  logic                i_ADC_DATA_VALID,
   output logic                o_ADC_DATA_READY,
   output logic [31:0]         o_X_DATA,
   output logic                o_X_DATA_VALID,
   input  logic                i_X_DATA_READY,
   output logic                o_OVERRUN,
   input  logic                i_OVR_CLR
);
   import ads_int_to_float_pkg::*;

   localparam int unsigned MSB      = IN_WIDTH - 1;
   localparam int unsigned FRAC_PAD = 24 - IN_WIDTH;
   localparam logic [7:0]  EXP_TOP  = 8'(FLOAT_EXP_BIAS + IN_WIDTH - 1);

   state_e              state_q,  state_d;
   logic [IN_WIDTH-1:0] sample_q, sample_d;
   logic [IN_WIDTH-1:0] mag_q,    mag_d;
   logic                sign_q,   sign_d;
   logic [7:0]          exp_q,    exp_d;
   logic [31:0]         x_data_q, x_data_d;
   logic                x_valid_q, x_valid_d;
   logic                ovr_q,    ovr_d;
   logic [22:0]         frac;

   assign o_ADC_DATA_READY = (state_q == ST_IDLE);
   assign o_X_DATA         = x_data_q;
   assign o_X_DATA_VALID   = x_valid_q;
   assign o_OVERRUN        = ovr_q;

   // Bits below the hidden one, left-justified into the 23-bit fraction.
   assign frac = 23'(mag_q[IN_WIDTH-2:0]) << FRAC_PAD;

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      mag_d    = mag_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      x_data_d = x_data_q;

      case (state_q)
         ST_IDLE: begin
            if (i_ADC_DATA_VALID) begin
               sample_d = i_ADC_DATA;
               state_d  = ST_ABS;
            end
         end
         ST_ABS: begin
            sign_d = sample_q[MSB];
            mag_d  = sample_q[MSB] ? (~sample_q + IN_WIDTH'(1)) : sample_q;
            exp_d  = EXP_TOP;
            if (sample_q == '0) begin
               x_data_d = FLOAT_ZERO;
               state_d  = ST_OUT;
            end else begin
               state_d  = ST_NORM;
            end
         end
         ST_NORM: begin
            if (!mag_q[MSB]) begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
            end else begin
               x_data_d = {sign_q, exp_q, frac};
               state_d  = ST_OUT;
            end
         end
         ST_OUT: begin
            if (i_X_DATA_READY) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      x_valid_d = (state_d == ST_OUT);

      // Set has priority over clear so no overrun event is ever lost.
      if (i_ADC_DATA_VALID && !o_ADC_DATA_READY) begin
         ovr_d = 1'b1;
      end else if (i_OVR_CLR) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= ST_IDLE;
         sample_q  <= '0;
         mag_q     <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         x_data_q  <= FLOAT_ZERO;
         x_valid_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sample_q  <= sample_d;
         mag_q     <= mag_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         x_data_q  <= x_data_d;
         x_valid_q <= x_valid_d;
         ovr_q     <= ovr_d;
      end
   end

endmodule

// File: tb/tb_ads_int_to_float.sv
// Directed and randomized checks of ads_int_to_float against a real-arithmetic float model.
module tb_ads_int_to_float;
   import ads_int_to_float_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] adc_data;
   logic        adc_valid;
   logic        adc_ready;
   logic [31:0] x_data;
   logic        x_valid;
   logic        x_ready;
   logic        ovr;
   logic        ovr_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ads_int_to_float #(.IN_WIDTH(24)) dut (
      .i_CLK            (clk),
      .i_RST            (rst),
      .i_ADC_DATA       (adc_data),
      .i_ADC_DATA_VALID (adc_valid),
      .o_ADC_DATA_READY (adc_ready),
      .o_X_DATA         (x_data),
      .o_X_DATA_VALID   (x_valid),
      .i_X_DATA_READY   (x_ready),
      .o_OVERRUN        (ovr),
      .i_OVR_CLR        (ovr_clr)
   );

   // Reference: go through a double and repack as single (exact for 24-bit integers).
   function automatic logic [31:0] ref_float(input logic [23:0] s);
      int          v;
      int          e;
      real         r;
      logic [63:0] d;
      v = int'($signed(s));
      if (v == 0) return 32'h0;
      r = v;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Expected accept-to-valid latency: leading zeros of |v| plus two, one for zero.
   function automatic int ref_lat(input logic [23:0] s);
      int          v;
      real         r;
      logic [63:0] d;
      v = int'($signed(s));
      if (v == 0) return 1;
      r = v;
      d = $realtobits(r);
      return (23 - (int'(d[62:52]) - 1023)) + 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!adc_ready && n < 60) begin
         step();
         n++;
      end
      chk({tag, " ready_wait"}, 32'(adc_ready), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!x_valid && n < 60) begin
         step();
         n++;
      end
      chk({tag, " valid_wait"}, 32'(x_valid), 32'd1);
   endtask

   task automatic offer(input logic [23:0] s);
      adc_data  = s;
      adc_valid = 1'b1;
      step();
      adc_valid = 1'b0;
   endtask

   // Always-ready conversion with latency, result and ready-return checks.
   task automatic convert(input logic [23:0] s, input string tag);
      int n = 0;
      wait_ready(tag);
      offer(s);
      while (!x_valid && n < 40) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(ref_lat(s)));
      chk({tag, " data"}, x_data, ref_float(s));
      step();
      chk({tag, " valid_drop"}, 32'(x_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(adc_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] held;
      logic [23:0] s;
      int          handshakes;
      int          n;
      logic        done;

      rst = 1'b1; adc_data = '0; adc_valid = 1'b0; x_ready = 1'b1; ovr_clr = 1'b0;
      step(); step();
      chk("reset data", x_data, FLOAT_ZERO);
      chk("reset valid", 32'(x_valid), 32'd0);
      chk("reset ready", 32'(adc_ready), 32'd1);
      chk("reset ovr", 32'(ovr), 32'd0);
      rst = 1'b0;
      step();

      // Full-range vectors and zero
      convert(24'h000001, "v_one");
      chk("v_one const", ref_float(24'h000001), FLOAT_ONE);
      convert(24'hFFFFFF, "v_m1");
      chk("v_m1 const", ref_float(24'hFFFFFF), 32'hBF80_0000);
      convert(24'h000100, "v_256");
      convert(24'h7FFFFF, "v_max");
      chk("v_max const", ref_float(24'h7FFFFF), 32'h4AFF_FFFE);
      convert(24'h800000, "v_min");
      chk("v_min const", ref_float(24'h800000), 32'hCB00_0000);
      convert(24'h000000, "v_zero");

      // Backpressure
      x_ready = 1'b0;
      wait_ready("bp");
      offer(24'h000100);
      wait_valid("bp");
      chk("bp data", x_data, 32'h4380_0000);
      held = x_data;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp hold data", x_data, held);
         chk("bp hold valid", 32'(x_valid), 32'd1);
         chk("bp hold ready", 32'(adc_ready), 32'd0);
      end
      x_ready = 1'b1;
      step();
      chk("bp release valid", 32'(x_valid), 32'd0);
      chk("bp release ready", 32'(adc_ready), 32'd1);

      // Overrun during normalisation
      offer(24'h000001);
      repeat (5) step();
      adc_data = 24'h123456; adc_valid = 1'b1;
      step();
      adc_valid = 1'b0;
      chk("ovr set", 32'(ovr), 32'd1);
      wait_valid("ovr");
      chk("ovr result", x_data, FLOAT_ONE);
      step();
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("ovr clr", 32'(ovr), 32'd0);
      wait_ready("ovr2");
      offer(24'h000001);
      repeat (3) step();
      adc_valid = 1'b1; ovr_clr = 1'b1;
      step();
      adc_valid = 1'b0; ovr_clr = 1'b0;
      chk("ovr set_wins", 32'(ovr), 32'd1);
      wait_valid("ovr2");
      chk("ovr2 result", x_data, FLOAT_ONE);
      step();
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;

      // Reset mid-normalisation
      wait_ready("rst");
      offer(24'h000001);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst data", x_data, FLOAT_ZERO);
      chk("midrst valid", 32'(x_valid), 32'd0);
      chk("midrst ready", 32'(adc_ready), 32'd1);
      chk("midrst ovr", 32'(ovr), 32'd0);
      convert(24'h000002, "post_rst");
      chk("post_rst const", ref_float(24'h000002), 32'h4000_0000);

      // Random stream into a sink with random ready
      handshakes = 0;
      for (int i = 0; i < 500; i++) begin
         s = 24'($urandom);
         s = 24'($signed(s) >>> $urandom_range(0, 23));
         wait_ready("stream");
         offer(s);
         n = 0;
         done = 1'b0;
         while (!done && n < 200) begin
            x_ready = 1'($urandom_range(0, 1));
            if (x_valid && x_ready) begin
               chk("stream data", x_data, ref_float(s));
               handshakes++;
               done = 1'b1;
            end
            step();
            n++;
         end
         chk("stream done", 32'(done), 32'd1);
      end
      x_ready = 1'b1;
      chk("stream count", 32'(handshakes), 32'd500);
      chk("stream ovr", 32'(ovr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
